// File: rtl/sprite_compositor.sv
// Composites up to NUM_OBJ prioritised rectangular sprites over a background colour.
// MMIO-programmed staging registers are copied to the active set atomically on vblank entry.
module sprite_compositor #(
  parameter int unsigned NUM_OBJ  = 4,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic [23:0] BG_COLOR = 24'h70C5CE,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               mmio_wr_en,
  input  logic               mmio_rd_en,
  input  logic [ADDR_W-1:0]  mmio_addr,
  input  logic [31:0]        mmio_wdata,
  output logic [31:0]        mmio_rdata,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic [15:0]        frame_count
);

  localparam int unsigned SEL_W = ADDR_W - 2;
  localparam int unsigned SUM_W = COORD_W + 1;
  localparam logic [ADDR_W-1:0]  CTRL_ADDR = ADDR_W'(4 * NUM_OBJ);
  localparam logic [COORD_W-1:0] H_LIM     = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM     = COORD_W'(V_ACTIVE);

  logic [COORD_W-1:0] stg_x_q [NUM_OBJ];
  logic [COORD_W-1:0] stg_y_q [NUM_OBJ];
  logic [COORD_W-1:0] stg_w_q [NUM_OBJ];
  logic [COORD_W-1:0] stg_h_q [NUM_OBJ];
  logic [23:0]        stg_rgb_q [NUM_OBJ];
  logic [NUM_OBJ-1:0] stg_en_q;

  logic [COORD_W-1:0] act_x_q [NUM_OBJ];
  logic [COORD_W-1:0] act_y_q [NUM_OBJ];
  logic [COORD_W-1:0] act_w_q [NUM_OBJ];
  logic [COORD_W-1:0] act_h_q [NUM_OBJ];
  logic [23:0]        act_rgb_q [NUM_OBJ];
  logic [NUM_OBJ-1:0] act_en_q;

  logic               pending_q, pending_d;
  logic [15:0]        frame_q, frame_d;
  logic               vb_q;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_OBJ-1:0] hit_q, hit_d;
  logic               blank_q, blank_d;
  logic [23:0]        rgb_q, rgb_d;

  logic               vblank_entry_c;
  logic               wr_obj_c;
  logic               commit_c;
  logic [SEL_W-1:0]   sel_c;
  logic [1:0]         off_c;
  logic               unused_c;

  assign unused_c = ^mmio_wdata[30:24];

  // MMIO decode, pending/frame bookkeeping and read mux
  always_comb begin
    vblank_entry_c = (row >= V_LIM) && !vb_q;
    sel_c          = mmio_addr[ADDR_W-1:2];
    off_c          = mmio_addr[1:0];
    wr_obj_c       = mmio_wr_en && (mmio_addr < CTRL_ADDR);
    commit_c       = mmio_wr_en && (mmio_addr == CTRL_ADDR) && mmio_wdata[0];

    frame_d   = vblank_entry_c ? frame_q + 16'd1 : frame_q;
    pending_d = pending_q;
    if (vblank_entry_c && pending_q) pending_d = 1'b0;
    // A commit landing on the vblank-entry cycle is held for the next frame
    if (commit_c) pending_d = 1'b1;

    rdata_d = '0;
    if (mmio_addr < CTRL_ADDR) begin
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
        if (sel_c == SEL_W'(i)) begin
          case (off_c)
            2'd0: begin
              rdata_d[COORD_W-1:0]  = stg_x_q[i];
              rdata_d[16+:COORD_W]  = stg_y_q[i];
            end
            2'd1: begin
              rdata_d[COORD_W-1:0]  = stg_w_q[i];
              rdata_d[16+:COORD_W]  = stg_h_q[i];
            end
            2'd2: begin
              rdata_d[31]    = stg_en_q[i];
              rdata_d[23:0]  = stg_rgb_q[i];
            end
            default: rdata_d = '0;
          endcase
        end
      end
    end else if (mmio_addr == CTRL_ADDR) begin
      rdata_d = {frame_q, 15'b0, pending_q};
    end
  end

  // Stage 1 hit test against the active set; sums are one bit wider so they never wrap
  always_comb begin
    hit_d   = '0;
    blank_d = (row >= V_LIM) || (col >= H_LIM);
    for (int i = 0; i < int'(NUM_OBJ); i++) begin
      hit_d[i] = act_en_q[i]
              && (col >= act_x_q[i])
              && (SUM_W'(col) < SUM_W'(act_x_q[i]) + SUM_W'(act_w_q[i]))
              && (row >= act_y_q[i])
              && (SUM_W'(row) < SUM_W'(act_y_q[i]) + SUM_W'(act_h_q[i]));
    end
  end

  // Stage 2 priority select: lowest index wins
  always_comb begin
    rgb_d = BG_COLOR;
    for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
      if (hit_q[i]) rgb_d = act_rgb_q[i];
    end
    if (blank_q) rgb_d = '0;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
        stg_x_q[i]   <= '0;
        stg_y_q[i]   <= '0;
        stg_w_q[i]   <= '0;
        stg_h_q[i]   <= '0;
        stg_rgb_q[i] <= '0;
        act_x_q[i]   <= '0;
        act_y_q[i]   <= '0;
        act_w_q[i]   <= '0;
        act_h_q[i]   <= '0;
        act_rgb_q[i] <= '0;
      end
      stg_en_q  <= '0;
      act_en_q  <= '0;
      pending_q <= 1'b0;
      frame_q   <= '0;
      vb_q      <= 1'b0;
      rdata_q   <= '0;
      hit_q     <= '0;
      blank_q   <= 1'b1;
      rgb_q     <= '0;
    end else begin
      vb_q      <= (row >= V_LIM);
      pending_q <= pending_d;
      frame_q   <= frame_d;
      if (mmio_rd_en) rdata_q <= rdata_d;

      for (int i = 0; i < int'(NUM_OBJ); i++) begin
        if (wr_obj_c && (sel_c == SEL_W'(i))) begin
          case (off_c)
            2'd0: begin
              stg_x_q[i] <= mmio_wdata[COORD_W-1:0];
              stg_y_q[i] <= mmio_wdata[16+:COORD_W];
            end
            2'd1: begin
              stg_w_q[i] <= mmio_wdata[COORD_W-1:0];
              stg_h_q[i] <= mmio_wdata[16+:COORD_W];
            end
            2'd2: begin
              stg_en_q[i]  <= mmio_wdata[31];
              stg_rgb_q[i] <= mmio_wdata[23:0];
            end
            default: ;
          endcase
        end
      end

      // Atomic copy uses pre-write staging values
      if (vblank_entry_c && pending_q) begin
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
          act_x_q[i]   <= stg_x_q[i];
          act_y_q[i]   <= stg_y_q[i];
          act_w_q[i]   <= stg_w_q[i];
          act_h_q[i]   <= stg_h_q[i];
          act_rgb_q[i] <= stg_rgb_q[i];
        end
        act_en_q <= stg_en_q;
      end

      hit_q   <= hit_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
    end
  end

  assign mmio_rdata  = rdata_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign frame_count = frame_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: MMIO programming, commit timing, pixel priority and edges.
module tb_sprite_compositor;

  localparam logic [23:0] BG  = 24'h70C5CE;
  localparam logic [7:0]  CTL = 8'd16;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        mmio_wr_en = 1'b0;
  logic        mmio_rd_en = 1'b0;
  logic [7:0]  mmio_addr  = '0;
  logic [31:0] mmio_wdata = '0;
  logic [31:0] mmio_rdata;
  logic [9:0]  row = 10'd10;
  logic [9:0]  col = 10'd10;
  logic [7:0]  red, green, blue;
  logic [15:0] frame_count;

  int n_vec = 0;
  int n_err = 0;

  sprite_compositor dut (
    .clock       (clock),
    .rst         (rst),
    .mmio_wr_en  (mmio_wr_en),
    .mmio_rd_en  (mmio_rd_en),
    .mmio_addr   (mmio_addr),
    .mmio_wdata  (mmio_wdata),
    .mmio_rdata  (mmio_rdata),
    .row         (row),
    .col         (col),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mmio_wr(input logic [7:0] a, input logic [31:0] d);
    mmio_wr_en = 1'b1;
    mmio_addr  = a;
    mmio_wdata = d;
    tick();
    mmio_wr_en = 1'b0;
  endtask

  task automatic mmio_rd(input logic [7:0] a, output logic [31:0] d);
    mmio_rd_en = 1'b1;
    mmio_addr  = a;
    tick();
    mmio_rd_en = 1'b0;
    d = mmio_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    mmio_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic pix(input string tag, input int r, input int c, input logic [23:0] exp);
    row = 10'(r);
    col = 10'(c);
    tick();
    tick();
    chk(tag, {8'h0, red, green, blue}, {8'h0, exp});
  endtask

  task automatic vblank();
    row = 10'd480;
    tick();
    row = 10'd0;
    tick();
  endtask

  initial begin
    // Reset state and pipeline fill
    #12;
    chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("rst_frame", {16'h0, frame_count}, 32'h0);
    chk("rst_rdata", mmio_rdata, 32'h0);
    rst = 1'b1;
    tick();
    chk("fill1_rgb", {8'h0, red, green, blue}, 32'h0);
    tick();
    chk("fill2_rgb", {8'h0, red, green, blue}, {8'h0, BG});
    rd_chk("rst_ctrl", CTL, 32'h0);

    // Object 0 programming and commit
    mmio_wr(8'd0, 32'h0032_0064);
    mmio_wr(8'd1, 32'h000A_0014);
    mmio_wr(8'd2, 32'h80FF_0000);
    rd_chk("stg0_xy", 8'd0, 32'h0032_0064);
    rd_chk("stg0_col", 8'd2, 32'h80FF_0000);
    rd_chk("stg0_rsv", 8'd3, 32'h0);
    mmio_wr(CTL, 32'h1);
    rd_chk("pend_set", CTL, 32'h0000_0001);
    pix("precommit", 50, 100, BG);
    vblank();
    chk("frame1", {16'h0, frame_count}, 32'd1);
    rd_chk("pend_clr", CTL, 32'h0001_0000);
    pix("o0_c99", 50, 99, BG);
    pix("o0_c100", 50, 100, 24'hFF0000);
    pix("o0_c119", 50, 119, 24'hFF0000);
    pix("o0_c120", 50, 120, BG);
    pix("o0_r59", 59, 100, 24'hFF0000);
    pix("o0_r60", 60, 100, BG);

    // Read in the same cycle as a write returns the old value
    mmio_rd_en = 1'b1;
    mmio_wr(8'd1, 32'h000A_0015);
    mmio_rd_en = 1'b0;
    chk("rd_wr_same", mmio_rdata, 32'h000A_0014);
    mmio_wr(8'd1, 32'h000A_0014);

    // Overlap priority, then disable obj0 mid-frame
    mmio_wr(8'd4, 32'h0032_0064);
    mmio_wr(8'd5, 32'h000A_0014);
    mmio_wr(8'd6, 32'h8000_FF00);
    mmio_wr(CTL, 32'h1);
    mmio_wr(CTL, 32'h1);
    vblank();
    pix("ovl_red", 50, 100, 24'hFF0000);
    mmio_wr(8'd2, 32'h00FF_0000);
    mmio_wr(CTL, 32'h1);
    pix("mid_frame", 55, 110, 24'hFF0000);
    vblank();
    pix("ovl_green", 50, 100, 24'h00FF00);
    chk("frame3", {16'h0, frame_count}, 32'd3);

    // Commit coinciding with vblank entry is deferred one frame
    mmio_wr(8'd6, 32'h8000_00FF);
    row = 10'd480;
    mmio_wr(CTL, 32'h1);
    row = 10'd0;
    tick();
    chk("frame4", {16'h0, frame_count}, 32'd4);
    rd_chk("pend_vb", CTL, 32'h0004_0001);
    pix("defer_green", 50, 100, 24'h00FF00);
    vblank();
    rd_chk("pend_vb2", CTL, 32'h0005_0000);
    pix("apply_blue", 50, 100, 24'h0000FF);

    // Right-edge clipping, zero-width object, unmapped addresses
    mmio_wr(8'd8, 32'h0000_0276);
    mmio_wr(8'd9, 32'h0005_0014);
    mmio_wr(8'd10, 32'h8012_3456);
    mmio_wr(8'd12, 32'h0000_0000);
    mmio_wr(8'd13, 32'h0064_0000);
    mmio_wr(8'd14, 32'h80AB_CDEF);
    mmio_wr(CTL, 32'h1);
    vblank();
    pix("edge_629", 2, 629, BG);
    pix("edge_630", 2, 630, 24'h123456);
    pix("edge_639", 2, 639, 24'h123456);
    pix("edge_640", 2, 640, 24'h0);
    pix("w0_nohit", 2, 0, BG);
    mmio_wr(8'hFF, 32'hFFFF_FFFF);
    rd_chk("addr_ff", 8'hFF, 32'h0);
    rd_chk("addr_11", 8'h11, 32'h0);
    mmio_wr(8'd7, 32'hFFFF_FFFF);
    rd_chk("rsv_7", 8'd7, 32'h0);
    // Repeated vblank hold: row stays >= 480 for several cycles
    row = 10'd500;
    tick(); tick(); tick();
    row = 10'd0;
    tick();
    chk("vb_once", {16'h0, frame_count}, 32'd7);

    // Asynchronous reset mid-frame with a pending commit
    mmio_wr(8'd2, 32'h80FF_0000);
    mmio_wr(CTL, 32'h1);
    rd_chk("pre_rst", CTL, 32'h0007_0001);
    row = 10'd2;
    col = 10'd630;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("arst_frame", {16'h0, frame_count}, 32'h0);
    chk("arst_rdata", mmio_rdata, 32'h0);
    tick();
    rst = 1'b1;
    rd_chk("post_ctrl", CTL, 32'h0);
    rd_chk("post_stg", 8'd2, 32'h0);
    pix("post_pix", 2, 630, BG);
    vblank();
    pix("post_vb", 50, 100, BG);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
